// File: rtl/fetch_stage.sv
// Program counter and fetch register: drives imem_addr, captures combinational imem_rdata
// and presents one instruction per cycle to decode over a valid/ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] END_PC     = 32'h0000_0038,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             out_is_cnn,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] fetch_count
);

    // One extra bit so IMEM_DEPTH*4 == 2**32 still compares correctly.
    localparam logic [32:0] LIMIT = 33'(IMEM_DEPTH) * 33'd4;

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic             r_out_valid;
    logic [31:0]      r_out_instr;
    logic [31:0]      r_out_pc;
    logic             r_out_is_cnn;
    logic             r_err;
    logic [CNT_W-1:0] r_fetch_count;

    logic             w_inrange;
    logic             w_slot;
    logic             w_fire;

    always_comb begin
        w_inrange   = ({1'b0, r_pc} < LIMIT);
        w_slot      = !r_out_valid || out_ready;
        w_fire      = (r_state == S_RUN) && w_slot && w_inrange && !redirect_valid;
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN) begin
            if (!w_inrange) begin
                w_state_nxt = S_HALT;
            end else if (w_fire && (r_pc == END_PC)) begin
                w_state_nxt = S_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_out_is_cnn  <= 1'b0;
            r_err         <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect_valid) begin
            r_pc        <= {redirect_pc[31:2], 2'b00};
            r_out_valid <= 1'b0;
        end else begin
            if (w_fire) begin
                r_out_instr  <= imem_rdata;
                r_out_pc     <= r_pc;
                r_out_is_cnn <= (imem_rdata[6:0] == 7'h2B);
                r_out_valid  <= 1'b1;
                r_pc         <= r_pc + 32'd4;
                if (r_fetch_count != '1) begin
                    r_fetch_count <= r_fetch_count + 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if ((r_state == S_RUN) && !w_inrange) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign out_is_cnn  = r_out_is_cnn;
    assign err         = r_err;
    assign fetch_count = r_fetch_count;
    assign done        = (r_state == S_HALT) && !r_out_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default program, stalls, redirect, range error,
// mid-run reset and counter saturation across three parameterisations.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] w;
        w = a[11:2];
        if (a >= 32'h0000_1000) return 32'hDEAD_BEEF;
        case (w)
            10'd0:   return 32'h0010_20ab;
            10'd1:   return 32'h0030_10ab;
            10'd4:   return 32'h0040_20ab;
            10'd14:  return 32'h0011_9133;
            default: return (w < 10'd14) ? {w, 22'h0020ab} : {w, 22'h000013};
        endcase
    endfunction

    // DUT A: default parameters
    logic        a_rst = 1'b1, a_redir = 1'b0, a_ready = 1'b0;
    logic [31:0] a_redir_pc = '0;
    logic [31:0] a_addr, a_instr, a_pc;
    logic        a_valid, a_cnn, a_done, a_err;
    logic [15:0] a_cnt;
    fetch_stage u_a (
        .clk(clk), .rst(a_rst), .imem_addr(a_addr), .imem_rdata(word_at(a_addr)),
        .redirect_valid(a_redir), .redirect_pc(a_redir_pc),
        .out_valid(a_valid), .out_ready(a_ready), .out_instr(a_instr), .out_pc(a_pc),
        .out_is_cnn(a_cnn), .done(a_done), .err(a_err), .fetch_count(a_cnt)
    );

    // DUT B: END_PC beyond memory, must stop on range error
    logic        b_rst = 1'b1, b_redir = 1'b0, b_ready = 1'b0;
    logic [31:0] b_redir_pc = '0;
    logic [31:0] b_addr, b_instr, b_pc;
    logic        b_valid, b_cnn, b_done, b_err;
    logic [15:0] b_cnt;
    fetch_stage #(.END_PC(32'h0000_1000), .IMEM_DEPTH(1024)) u_b (
        .clk(clk), .rst(b_rst), .imem_addr(b_addr), .imem_rdata(word_at(b_addr)),
        .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
        .out_valid(b_valid), .out_ready(b_ready), .out_instr(b_instr), .out_pc(b_pc),
        .out_is_cnn(b_cnn), .done(b_done), .err(b_err), .fetch_count(b_cnt)
    );

    // DUT C: 4-bit fetch counter
    logic        c_rst = 1'b1, c_redir = 1'b0, c_ready = 1'b0;
    logic [31:0] c_redir_pc = '0;
    logic [31:0] c_addr, c_instr, c_pc;
    logic        c_valid, c_cnn, c_done, c_err;
    logic [3:0]  c_cnt;
    fetch_stage #(.CNT_W(4)) u_c (
        .clk(clk), .rst(c_rst), .imem_addr(c_addr), .imem_rdata(word_at(c_addr)),
        .redirect_valid(c_redir), .redirect_pc(c_redir_pc),
        .out_valid(c_valid), .out_ready(c_ready), .out_instr(c_instr), .out_pc(c_pc),
        .out_is_cnn(c_cnn), .done(c_done), .err(c_err), .fetch_count(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the default program on DUT A with out_ready low for cycles st_lo..st_hi.
    task automatic run_a(input int st_lo, input int st_hi);
        int          idx;
        logic        pv, pr, fin;
        logic [31:0] ppc, pins;
        idx = 0; pv = 1'b0; pr = 1'b1; fin = 1'b0; ppc = '0; pins = '0;
        for (int c = 0; c < 100 && !fin; c++) begin
            a_ready = !(c >= st_lo && c <= st_hi);
            if (pv && !pr) begin
                chk("a_hold_pc", a_pc, ppc);
                chk("a_hold_instr", a_instr, pins);
            end
            if (a_valid && a_ready) begin
                chk("a_seq_pc", a_pc, 32'(idx * 4));
                chk("a_seq_instr", a_instr, word_at(32'(idx * 4)));
                chk("a_seq_cnn", {31'b0, a_cnn}, {31'b0, (idx != 14)});
                idx++;
            end
            pv = a_valid; pr = a_ready; ppc = a_pc; pins = a_instr;
            if (a_done) fin = 1'b1;
            else tick();
        end
        chk("a_finished", {31'b0, fin}, 32'd1);
        chk("a_accept_count", 32'(idx), 32'd15);
        chk("a_fetch_count", {16'b0, a_cnt}, 32'd15);
        chk("a_halt_addr", a_addr, 32'h3C);
        chk("a_err", {31'b0, a_err}, 32'd0);
    endtask

    initial begin
        int          n;
        int          bad;
        int          nacc;
        logic [31:0] last_pc;
        logic        fin;

        // Reset state
        tick();
        chk("rst_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_instr", a_instr, 32'h0);
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_cnt", {16'b0, a_cnt}, 32'd0);
        chk("rst_err", {31'b0, a_err}, 32'd0);
        chk("rst_done", {31'b0, a_done}, 32'd0);

        // Straight-line program, then stalled program
        a_rst = 1'b0;
        run_a(-1, -1);
        tick();
        chk("a_halt_frozen_addr", a_addr, 32'h3C);
        chk("a_halt_frozen_cnt", {16'b0, a_cnt}, 32'd15);

        // Redirect leaves HALT
        a_redir = 1'b1; a_redir_pc = 32'h0000_000B;
        tick();
        a_redir = 1'b0;
        chk("a_exit_halt_valid", {31'b0, a_valid}, 32'd0);
        chk("a_exit_halt_addr", a_addr, 32'h8);
        tick();
        chk("a_exit_halt_pc", a_pc, 32'h8);
        chk("a_exit_halt_done", {31'b0, a_done}, 32'd0);

        a_rst = 1'b1; tick(); a_rst = 1'b0;
        run_a(3, 6);

        // Redirect while out_valid=1
        a_rst = 1'b1; tick(); a_rst = 1'b0; a_ready = 1'b1;
        tick(); tick();
        chk("rd_pre_valid", {31'b0, a_valid}, 32'd1);
        chk("rd_pre_pc", a_pc, 32'h4);
        a_redir = 1'b1; a_redir_pc = 32'h0000_0013;
        tick();
        a_redir = 1'b0;
        chk("rd_flush_valid", {31'b0, a_valid}, 32'd0);
        chk("rd_addr", a_addr, 32'h10);
        tick();
        chk("rd_valid", {31'b0, a_valid}, 32'd1);
        chk("rd_pc", a_pc, 32'h10);
        chk("rd_instr", a_instr, 32'h0040_20ab);
        chk("rd_cnt", {16'b0, a_cnt}, 32'd3);

        // Reset mid-run with a held instruction
        a_ready = 1'b0;
        tick();
        chk("mr_held_valid", {31'b0, a_valid}, 32'd1);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0; a_ready = 1'b1;
        chk("mr_valid", {31'b0, a_valid}, 32'd0);
        chk("mr_addr", a_addr, 32'h0);
        chk("mr_cnt", {16'b0, a_cnt}, 32'd0);
        tick();
        chk("mr_restart_pc", a_pc, 32'h0);
        chk("mr_restart_instr", a_instr, 32'h0010_20ab);

        // Range error with unreachable END_PC
        b_rst = 1'b0; b_ready = 1'b1;
        bad = 0; nacc = 0; last_pc = '1; fin = 1'b0;
        for (int c = 0; c < 1100 && !fin; c++) begin
            if (b_valid) begin
                if (b_pc != 32'(nacc * 4)) bad++;
                last_pc = b_pc;
                nacc++;
            end
            if (b_done) fin = 1'b1;
            else tick();
        end
        chk("b_finished", {31'b0, fin}, 32'd1);
        chk("b_seq_bad", 32'(bad), 32'd0);
        chk("b_accept_count", 32'(nacc), 32'd1024);
        chk("b_last_pc", last_pc, 32'hFFC);
        chk("b_err", {31'b0, b_err}, 32'd1);
        chk("b_cnt", {16'b0, b_cnt}, 32'd1024);
        tick(); tick();
        chk("b_frozen_addr", b_addr, 32'h1000);
        chk("b_frozen_done", {31'b0, b_done}, 32'd1);
        b_redir = 1'b1; b_redir_pc = 32'h0;
        tick();
        b_redir = 1'b0;
        chk("b_err_sticky", {31'b0, b_err}, 32'd1);
        tick();
        chk("b_redirect_resume", b_pc, 32'h0);

        // Counter saturation via redirect loops
        c_rst = 1'b0; c_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 80 && n < 20; c++) begin
            if (c_valid) begin
                n++;
                if (n == 10) chk("c_cnt_10", {28'b0, c_cnt}, 32'd10);
            end
            if (c_done) begin
                c_redir = 1'b1; c_redir_pc = 32'h0;
                tick();
                c_redir = 1'b0;
            end else begin
                tick();
            end
        end
        chk("c_fetches", 32'(n), 32'd20);
        chk("c_cnt_sat", {28'b0, c_cnt}, 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
